bit_serial_subtractor: RTL and testbench
========================================

# bit_serial_subtractor

Bit-serial two's-complement subtractor; the inverse-operation companion to the team's bit-serial adder, with the same load/start/done handshake. Operands are captured in parallel, processed LSB-first one bit per clock through a single full-subtractor cell and borrow flip-flop, and the difference is returned in parallel with a borrow flag. It sits beside the adder in the serial-arithmetic datapath.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- load  input  1  capture A and B into operand shift registers
- start  input  1  begin serial subtraction of loaded operands
- A  input  WIDTH  minuend, unsigned
- B  input  WIDTH  subtrahend, unsigned
- diff  output  WIDTH  difference (A−B) mod 2^WIDTH, valid when done=1
- borrow  output  1  final borrow-out; 1 iff A<B; valid when done=1
- busy  output  1  high while in RUN
- done  output  1  high in DONE; held until next load or reset

## Operation
- States: IDLE, LOADED, RUN, DONE.
- IDLE: start ignored. load → capture A, B into shift registers sa, sb; clear diff, borrow, done; go LOADED.
- LOADED: load → recapture (stay LOADED). start (without load) → clear bit counter and borrow FF to 0; go RUN.
- RUN, per cycle: a=sa[0], b=sb[0], br=borrow FF.
  - d = a^b^br
  - br_next = (~a & b) | (~(a^b) & br)
  - diff <= {d, diff[WIDTH-1:1]}; sa, sb shift right by 1; counter++.
  - After the WIDTH-th bit: borrow <= br_next; go DONE.
- RUN ignores load and start.
- DONE: done=1; diff and borrow hold. load → as in IDLE (clears done, go LOADED). start ignored.
- load and start asserted together: load wins; start is discarded.
- Counter width: $clog2(WIDTH)+1. No wrap: the counter is reset on every start.
- Intermediate diff/borrow during RUN are not valid. Only done qualifies them.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE; diff=0, borrow=0, busy=0, done=0; shift registers and counter 0. Reset during RUN aborts the operation with no partial result kept.
- load sampled at edge L: state LOADED after L.
- start sampled at edge S (state LOADED): busy=1 after S.
- Bit i is processed at edge S+1+i, for i=0..WIDTH-1.
- After edge S+WIDTH: done=1, busy=0, diff and borrow final.
- Latency from start to done is WIDTH cycles. busy is high for exactly WIDTH cycles.
- done stays high indefinitely until a load or reset is sampled. It falls on the same edge that loads new operands.
- Throughput: one result per WIDTH+2 cycles (load, start, WIDTH run cycles), with back-to-back load allowed in DONE.

## Test plan
- Reset: hold rst_n=0 for 2 edges → diff=0, borrow=0, busy=0, done=0. Release; start alone → no busy, done stays 0.
- Basic subtraction: load A=13, B=11; start → busy for 4 cycles; done after edge S+4 with diff=2, borrow=0. done holds until next load.
- Underflow: A=11, B=13 → diff=14, borrow=1. Boundary cases: A=0, B=15 → diff=1, borrow=1. A=15, B=0 → diff=15, borrow=0. A=B=9 → diff=0, borrow=0.
- Handshake corners:
  - load+start in the same cycle from IDLE → state LOADED only, no run.
  - load in RUN with A=1, B=1 → ignored; original 13−11 result (2) delivered.
  - start in DONE → no restart.
- Reset mid-run: A=13, B=11, start; assert rst_n=0 at edge S+2 → all outputs 0, IDLE. Reload 7−3 → diff=4, borrow=0.
- Scoreboarded sweep at WIDTH=4: all 256 (A,B) pairs, back-to-back load/start → diff=(A−B)&15 and borrow=(A<B), each exactly 4 cycles after start.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor.
// Operands are captured in parallel, then consumed LSB-first, one bit per clock, through a
// single full-subtractor cell and a borrow flip-flop. The difference is collected MSB-in
// into a parallel result register. The final borrow-out is 1 iff A < B.
module bit_serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoaded,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;        // running borrow between bit slices
  logic             borrow_q, borrow_d; // published borrow-out, valid with done

  logic bit_a, bit_b, bit_d, bit_br_next;
  logic last_bit;
  logic do_capture;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    bit_a       = sa_q[0];
    bit_b       = sb_q[0];
    bit_d       = bit_a ^ bit_b ^ br_q;
    bit_br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    last_bit    = (cnt_q == CntW'(WIDTH - 1));
  end

  // Loads are honoured in every state except RUN and always beat a concurrent start.
  always_comb begin
    do_capture = load && (state_q != StRun);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle: begin
        // start is meaningless without operands
      end
      StLoaded: begin
        if (start && !load) begin
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        diff_d = {bit_d, diff_q[WIDTH-1:1]};
        br_d   = bit_br_next;
        cnt_d  = cnt_q + CntW'(1);
        if (last_bit) begin
          borrow_d = bit_br_next;
          state_d  = StDone;
        end
      end
      StDone: begin
        // result holds; start ignored
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (do_capture) begin
      sa_d     = A;
      sb_d     = B;
      diff_d   = '0;
      borrow_d = 1'b0;
      state_d  = StLoaded;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
    end
  end

  // Outputs decoded straight from registered state.
  always_comb begin
    diff   = diff_q;
    borrow = borrow_q;
    busy   = (state_q == StRun);
    done   = (state_q == StDone);
  end

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor at WIDTH=4.
module tb_bit_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;

  int n_tests;
  int n_failed;

  bit_serial_subtractor #(
    .WIDTH(WIDTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .start (start),
    .A     (A),
    .B     (B),
    .diff  (diff),
    .borrow(borrow),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    load = 1'b1;
    A    = a;
    B    = b;
    tick();
    load = 1'b0;
  endtask

  // Pulse start from LOADED and check the full WIDTH-cycle run and the result.
  task automatic finish_run(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_b);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, " busy@S"}, 32'(busy), 32'd1);
    for (int i = 1; i < int'(WIDTH); i++) begin
      tick();
      check_eq({tag, " busy mid"}, 32'(busy), 32'd1);
      check_eq({tag, " done mid"}, 32'(done), 32'd0);
    end
    tick();
    check_eq({tag, " done"}, 32'(done), 32'd1);
    check_eq({tag, " busy end"}, 32'(busy), 32'd0);
    check_eq({tag, " diff"}, 32'(diff), 32'(exp_d));
    check_eq({tag, " borrow"}, 32'(borrow), 32'(exp_b));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b);
    do_load(a, b);
    check_eq({tag, " load busy"}, 32'(busy), 32'd0);
    check_eq({tag, " load done"}, 32'(done), 32'd0);
    check_eq({tag, " load diff"}, 32'(diff), 32'd0);
    finish_run(tag, exp_d, exp_b);
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    A        = '0;
    B        = '0;

    // Reset
    tick();
    tick();
    check_eq("rst diff", 32'(diff), 32'd0);
    check_eq("rst borrow", 32'(borrow), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("idle start busy", 32'(busy), 32'd0);
    tick();
    check_eq("idle start done", 32'(done), 32'd0);

    // Basic, underflow and boundary cases
    run_op("13-11", 4'd13, 4'd11, 4'd2, 1'b0);
    tick();
    tick();
    check_eq("13-11 done hold", 32'(done), 32'd1);
    check_eq("13-11 diff hold", 32'(diff), 32'd2);
    run_op("11-13", 4'd11, 4'd13, 4'd14, 1'b1);
    run_op("0-15", 4'd0, 4'd15, 4'd1, 1'b1);
    run_op("15-0", 4'd15, 4'd0, 4'd15, 1'b0);
    run_op("9-9", 4'd9, 4'd9, 4'd0, 1'b0);

    // Load in DONE clears the result
    do_load(4'd5, 4'd3);
    check_eq("reload done", 32'(done), 32'd0);
    check_eq("reload diff", 32'(diff), 32'd0);
    check_eq("reload borrow", 32'(borrow), 32'd0);

    // load+start together from IDLE: load wins, no run
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    load  = 1'b1;
    start = 1'b1;
    A     = 4'd5;
    B     = 4'd3;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check_eq("ld+st busy", 32'(busy), 32'd0);
    tick();
    check_eq("ld+st busy2", 32'(busy), 32'd0);
    check_eq("ld+st done", 32'(done), 32'd0);
    finish_run("ld+st 5-3", 4'd2, 1'b0);

    // load during RUN is ignored
    do_load(4'd13, 4'd11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    load = 1'b1;
    A    = 4'd1;
    B    = 4'd1;
    tick();
    load = 1'b0;
    check_eq("run load busy", 32'(busy), 32'd1);
    tick();
    tick();
    check_eq("run load done", 32'(done), 32'd1);
    check_eq("run load diff", 32'(diff), 32'd2);
    check_eq("run load borrow", 32'(borrow), 32'd0);

    // start in DONE does not restart
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("done start busy", 32'(busy), 32'd0);
    check_eq("done start done", 32'(done), 32'd1);
    check_eq("done start diff", 32'(diff), 32'd2);

    // Reset mid-run
    do_load(4'd13, 4'd11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst diff", 32'(diff), 32'd0);
    check_eq("midrst borrow", 32'(borrow), 32'd0);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst done", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("midrst idle start", 32'(busy), 32'd0);
    run_op("7-3", 4'd7, 4'd3, 4'd4, 1'b0);

    // Exhaustive back-to-back sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op("sweep", 4'(a), 4'(b), 4'((a - b) & 15), (a < b));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
